// File: rtl/bcd3_timer.sv
// -----------------------------------------------------------------------------
// bcd3_timer
//   Three-digit BCD reaction/run timer with a tick prescaler, saturation at 999,
//   an end-of-run pulse and optional best (lowest) run time tracking.
//
//   Optional feature macro: BCD3_BEST_TIME_EN
//     defined   -> best / best_valid track the lowest valid run time
//     undefined -> best = 0x000, best_valid = 0, no best registers
//
//   Parameters
//     TICK_DIV    enabled clk cycles per count increment
//
//   Ports
//     clk         system clock, rising edge
//     ar          asynchronous reset, active low
//     ctr_en      count enable, high = run
//     ctr_ar      synchronous count clear, active low (beats ctr_en and ticks)
//     bcd[11:0]   count, {hundreds, tens, units}
//     ovf         sticky saturation flag (count reached 999 and ticked again)
//     done        one-cycle pulse when a run ends (ctr_en falls, no clear)
//     best[11:0]  lowest valid run time seen, BCD
//     best_valid  best holds a real result
// -----------------------------------------------------------------------------
module bcd3_timer #(
    parameter int unsigned TICK_DIV = 10000
) (
    input  logic        clk,
    input  logic        ar,
    input  logic        ctr_en,
    input  logic        ctr_ar,
    output logic [11:0] bcd,
    output logic        ovf,
    output logic        done,
    output logic [11:0] best,
    output logic        best_valid
);

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [11:0]   bcd_inc;
    logic          en_d;
    logic          run_end;

    // BCD +1 with ripple carry; the 999 case is handled by the caller.
    always_comb begin
        bcd_inc = bcd;
        if (bcd[3:0] != 4'd9) begin
            bcd_inc[3:0] = bcd[3:0] + 4'd1;
        end else begin
            bcd_inc[3:0] = '0;
            if (bcd[7:4] != 4'd9) begin
                bcd_inc[7:4] = bcd[7:4] + 4'd1;
            end else begin
                bcd_inc[7:4]  = '0;
                bcd_inc[11:8] = bcd[11:8] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            presc <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else if (!ctr_ar) begin
            presc <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else if (ctr_en) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
                if (bcd == 12'h999) begin
                    ovf <= 1'b1;
                end else begin
                    bcd <= bcd_inc;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Falling ctr_en ends a run unless the same edge clears the count.
    assign run_end = en_d && !ctr_en && ctr_ar;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            en_d <= 1'b0;
            done <= 1'b0;
        end else begin
            en_d <= ctr_en;
            done <= run_end;
        end
    end

`ifdef BCD3_BEST_TIME_EN
    // Updated on the same edge that raises done; ctr_ar deliberately not used.
    // Packed BCD compares correctly as plain unsigned.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            best       <= '0;
            best_valid <= 1'b0;
        end else if (run_end && (bcd != '0) && !ovf && (!best_valid || (bcd < best))) begin
            best       <= bcd;
            best_valid <= 1'b1;
        end
    end
`else
    assign best       = '0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd3_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd3_timer
//   Directed bench for bcd3_timer at TICK_DIV=4. Best-time expectations follow
//   whether BCD3_BEST_TIME_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_bcd3_timer;

`ifdef BCD3_BEST_TIME_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        ar;
    logic        ctr_en;
    logic        ctr_ar;
    logic [11:0] bcd;
    logic        ovf;
    logic        done;
    logic [11:0] best;
    logic        best_valid;

    int n_checks = 0;
    int n_fails  = 0;

    bcd3_timer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .ar         (ar),
        .ctr_en     (ctr_en),
        .ctr_ar     (ctr_ar),
        .bcd        (bcd),
        .ovf        (ovf),
        .done       (done),
        .best       (best),
        .best_valid (best_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // n rising edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_best(input logic [11:0] v);
        return BEST_ON ? v : 12'h000;
    endfunction

    // clear, run for n_ticks ticks, stop; checks final count, done and best
    task automatic run(input string tag, input int n_ticks, input logic [11:0] exp_bcd,
                       input logic [11:0] exp_b, input logic exp_bv);
        ctr_ar = 1'b0;
        step(1);
        ctr_ar = 1'b1;
        ctr_en = 1'b1;
        step(4 * n_ticks);
        ctr_en = 1'b0;
        step(1);
        check({tag, " bcd"},  bcd, exp_bcd);
        check({tag, " done"}, {11'd0, done}, 12'd1);
        check({tag, " best"}, best, exp_best(exp_b));
        check({tag, " bv"},   {11'd0, best_valid}, {11'd0, exp_bv & BEST_ON});
        step(1);
        check({tag, " done1"}, {11'd0, done}, 12'd0);
    endtask

    initial begin
        ar     = 1'b0;
        ctr_en = 1'b0;
        ctr_ar = 1'b1;
        step(2);
        check("rst bcd",  bcd, 12'h000);
        check("rst ovf",  {11'd0, ovf}, 12'd0);
        check("rst done", {11'd0, done}, 12'd0);
        check("rst best", best, 12'h000);
        check("rst bv",   {11'd0, best_valid}, 12'd0);
        ar = 1'b1;
        step(1);

        // 40 enabled cycles -> ten ticks
        ctr_en = 1'b1;
        step(3);
        check("pre tick", bcd, 12'h000);
        step(1);
        check("first tick", bcd, 12'h001);
        step(36);
        check("40 cyc", bcd, 12'h010);
        ctr_en = 1'b0;
        step(1);
        check("stop bcd",  bcd, 12'h010);
        check("stop done", {11'd0, done}, 12'd1);
        step(1);
        check("stop done1", {11'd0, done}, 12'd0);
        step(5);
        check("frozen bcd", bcd, 12'h010);
        check("frozen done", {11'd0, done}, 12'd0);

        // reset to restart best tracking
        ar = 1'b0;
        #1;
        check("ar best", best, 12'h000);
        ar = 1'b1;
        step(1);

        run("r25", 25, 12'h025, 12'h025, 1'b1);
        run("r30", 30, 12'h030, 12'h025, 1'b1);
        run("r12", 12, 12'h012, 12'h012, 1'b1);

        // zero run: no tick reached
        ctr_ar = 1'b0;
        step(1);
        ctr_ar = 1'b1;
        ctr_en = 1'b1;
        step(2);
        ctr_en = 1'b0;
        step(1);
        check("zero done", {11'd0, done}, 12'd1);
        check("zero best", best, exp_best(12'h012));

        // carry chain and saturation
        ctr_ar = 1'b0;
        step(1);
        ctr_ar = 1'b1;
        ctr_en = 1'b1;
        step(4 * 99);
        check("to 099", bcd, 12'h099);
        step(4);
        check("to 100", bcd, 12'h100);
        step(4 * 899);
        check("to 999", bcd, 12'h999);
        check("999 ovf", {11'd0, ovf}, 12'd0);
        step(4);
        check("sat bcd", bcd, 12'h999);
        check("sat ovf", {11'd0, ovf}, 12'd1);
        step(8);
        check("sat hold", bcd, 12'h999);
        check("ovf sticky", {11'd0, ovf}, 12'd1);
        ctr_en = 1'b0;
        step(1);
        check("ovf done", {11'd0, done}, 12'd1);
        check("ovf best", best, exp_best(12'h012));
        check("ovf bv", {11'd0, best_valid}, {11'd0, BEST_ON});
        ctr_ar = 1'b0;
        step(1);
        ctr_ar = 1'b1;
        check("clr bcd", bcd, 12'h000);
        check("clr ovf", {11'd0, ovf}, 12'd0);
        check("clr best", best, exp_best(12'h012));

        // ctr_en falls on the same edge ctr_ar clears
        ctr_en = 1'b1;
        step(10);
        check("pre clr", bcd, 12'h002);
        ctr_en = 1'b0;
        ctr_ar = 1'b0;
        step(1);
        check("fall clr bcd",  bcd, 12'h000);
        check("fall clr done", {11'd0, done}, 12'd0);
        ctr_ar = 1'b1;
        step(1);
        check("fall clr done1", {11'd0, done}, 12'd0);

        // clear on a tick cycle wins, and resets the prescaler
        ctr_en = 1'b1;
        step(3);
        ctr_ar = 1'b0;
        step(1);
        check("clr tick", bcd, 12'h000);
        ctr_ar = 1'b1;
        step(3);
        check("presc cleared", bcd, 12'h000);
        step(1);
        check("presc restart", bcd, 12'h001);

        // prescaler holds while disabled
        step(2);
        ctr_en = 1'b0;
        step(5);
        ctr_en = 1'b1;
        step(1);
        check("presc hold a", bcd, 12'h001);
        step(1);
        check("presc hold b", bcd, 12'h002);
        ctr_en = 1'b0;
        step(2);

        // async reset mid-run at 0x037
        ctr_ar = 1'b0;
        step(1);
        ctr_ar = 1'b1;
        ctr_en = 1'b1;
        step(4 * 37);
        check("mid 037", bcd, 12'h037);
        #2;
        ar = 1'b0;
        #1;
        check("ar bcd",  bcd, 12'h000);
        check("ar ovf",  {11'd0, ovf}, 12'd0);
        check("ar done", {11'd0, done}, 12'd0);
        check("ar best2", best, 12'h000);
        check("ar bv",   {11'd0, best_valid}, 12'd0);
        ctr_en = 1'b0;
        step(2);
        check("ar hold done", {11'd0, done}, 12'd0);
        ar = 1'b1;
        step(1);
        check("ar rel done", {11'd0, done}, 12'd0);
        step(1);
        check("ar rel done2", {11'd0, done}, 12'd0);
        check("ar rel bcd", bcd, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bcd3_timer.md
BCD3_TIMER -- requirements
Module: bcd3_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000, meaning enabled clk cycles per count increment (1 ms at a 10 MHz clk).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port ar  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port ctr_en  input  1  count enable from the game FSM; high means run.
REQ-005 SHALL have port ctr_ar  input  1  count clear from the game FSM; synchronous, active-low.
REQ-006 SHALL have port bcd  output  12  count value as three BCD digits, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 SHALL have port ovf  output  1  sticky flag; count saturated at 999.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking the end of a run.
REQ-009 SHALL have port best  output  12  lowest valid run time seen, in BCD.
REQ-010 SHALL have port best_valid  output  1  high when best holds a real result.

Function
REQ-011 SHALL use a prescaler of width clog2(TICK_DIV), counting 0..TICK_DIV-1 while ctr_en=1 and ctr_ar=1, then wrapping to 0 and producing a tick.
REQ-012 SHALL hold the prescaler, without clearing it, while ctr_en=0.
REQ-013 SHALL make the first increment visible on bcd TICK_DIV enabled cycles after ctr_en rises from a cleared state.
REQ-014 SHALL advance bcd by 1 on each tick, in BCD: units 9->0 with carry to tens; tens 9->0 with carry to hundreds; no digit ever exceeds 9.
REQ-015 SHALL, on a tick while bcd=0x999, hold bcd at 0x999 and set ovf=1.
REQ-016 SHALL keep ovf set until ctr_ar=0 or ar=0.
REQ-017 SHALL, on any edge with ctr_ar=0, clear bcd, the prescaler and ovf; ctr_ar has priority over ctr_en and over a coincident tick.
REQ-018 SHALL register ctr_en as en_d and assert done for exactly one cycle when en_d=1, ctr_en=0 and ctr_ar=1.
REQ-019 SHALL NOT assert done when ctr_en falls in the same cycle that ctr_ar=0.
REQ-020 SHALL, on the edge that asserts done, load best<=bcd and set best_valid<=1 when all of the following hold: bcd!=0, ovf=0, and (best_valid=0 or bcd<best). Packed-BCD unsigned compare is valid.
REQ-021 SHALL make the best update visible in the same cycle as the done pulse.
REQ-022 SHALL NOT let ctr_ar clear best or best_valid.
REQ-023 SHALL leave bcd frozen while ctr_en=0 so the FSM STOPPED state displays the final time.

Reset
REQ-024 SHALL, while ar=0, force bcd=0, prescaler=0, ovf=0, en_d=0, done=0, best=0 and best_valid=0, regardless of clk.
REQ-025 SHALL, when ar=0 arrives mid-run, abort immediately with no done pulse and no best update.

Configuration
REQ-026 SHALL compile best-time tracking (REQ-020..REQ-022) in only when macro BCD3_BEST_TIME_EN is defined.
REQ-027 SHALL, without BCD3_BEST_TIME_EN, drive best=0x000 and best_valid=0 constantly and instantiate no best registers; all other behaviour is unchanged.

Verification (TICK_DIV=4, macro defined unless noted)
REQ-028 SHALL cover: ar=0 mid-count at bcd=0x037 -> all outputs 0 immediately, no done pulse.
REQ-029 SHALL cover: ctr_ar=1, ctr_en=1 for 40 cycles from clear -> bcd=0x010; ctr_en=0 -> bcd holds 0x010 and done pulses once.
REQ-030 SHALL cover: count to 0x099 then 4 more enabled cycles -> bcd=0x100; count to 0x999 then 4 more -> bcd=0x999, ovf=1; ctr_ar=0 for one cycle -> bcd=0x000, ovf=0.
REQ-031 SHALL cover: runs stopping at 0x025, 0x030, then 0x012 -> best=0x025 (valid), then 0x025, then 0x012; an overflowed run or a zero run leaves best unchanged.
REQ-032 SHALL cover: ctr_en 1->0 in the same cycle ctr_ar=0 -> bcd=0x000, no done pulse; ctr_ar=0 with ctr_en=1 on a tick cycle -> no increment.
REQ-033 SHALL cover: macro undefined, scenario of REQ-031 -> best=0x000 and best_valid=0 throughout, done pulses as before.
